// File: rtl/ring_buffer_snapshot_reader.sv
// rtl/ring_buffer_snapshot_reader.sv - captures a ring buffer debug snapshot and streams its valid slots oldest-first
module ring_buffer_snapshot_reader #(
    parameter int width = 256,
    parameter int depth = 10,
    localparam int iw = $clog2(depth)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         snap_req,
    input  logic [iw-1:0]                start_idx,
    input  logic [depth-1:0]             snap_valid,
    input  logic [depth-1:0][width-1:0]  snap_data,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [width-1:0]             out_data,
    output logic [iw-1:0]                out_idx,
    output logic                         out_last,
    output logic                         done
);

    typedef enum logic {IDLE, WALK} state_t;

    localparam logic [iw-1:0] last_idx = iw'(depth - 1);

    state_t                        state;
    logic [depth-1:0]              shadow_valid;
    logic [depth-1:0][width-1:0]   shadow_data;
    logic [iw-1:0]                 idx;
    logic [iw-1:0]                 cnt;
    logic                          consume;
    logic [depth-1:0]              ahead;
    logic [depth-1:0]              window;

    assign busy      = (state == WALK);
    assign out_valid = busy & shadow_valid[idx];
    assign out_data  = shadow_data[idx];
    assign out_idx   = idx;
    assign consume   = busy & (~shadow_valid[idx] | out_ready);

    // ahead[k] is the valid bit k slots past idx; window keeps only slots not yet visited
    assign ahead  = depth'({shadow_valid, shadow_valid} >> idx);
    assign window = ({depth{1'b1}} >> ({1'b0, cnt} + 1'b1)) << 1;
    assign out_last = out_valid & ~|(ahead & window);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shadow_valid <= '0;
            idx          <= '0;
            cnt          <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (snap_req) begin
                        shadow_valid <= snap_valid;
                        idx          <= (int'(start_idx) >= depth) ? '0 : start_idx;
                        cnt          <= '0;
                        state        <= WALK;
                    end
                end
                WALK: begin
                    if (consume) begin
                        idx <= (idx == last_idx) ? '0 : idx + 1'b1;
                        cnt <= cnt + 1'b1;
                        if (cnt == last_idx) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data shadow carries no reset; it is only observed through a set shadow_valid bit.
    always_ff @(posedge clk) begin
        if (state == IDLE && snap_req) begin
            shadow_data <= snap_data;
        end
    end

endmodule

// File: tb/tb_ring_buffer_snapshot_reader.sv
// tb/tb_ring_buffer_snapshot_reader.sv - scoreboard bench for ring_buffer_snapshot_reader at depth 4 and depth 5
module tb_ring_buffer_snapshot_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            req4 = 1'b0, rdy4 = 1'b1;
    logic [1:0]      st4 = '0;
    logic [3:0]      sv4 = '0;
    logic [3:0][7:0] sd4 = '0;
    logic            busy4, ov4, ol4, dn4;
    logic [7:0]      od4;
    logic [1:0]      oi4;

    logic            req5 = 1'b0, rdy5 = 1'b1;
    logic [2:0]      st5 = '0;
    logic [4:0]      sv5 = '0;
    logic [4:0][7:0] sd5 = '0;
    logic            busy5, ov5, ol5, dn5;
    logic [7:0]      od5;
    logic [2:0]      oi5;

    ring_buffer_snapshot_reader #(.width(8), .depth(4)) u_dut4 (
        .clk(clk), .rst(rst), .snap_req(req4), .start_idx(st4), .snap_valid(sv4),
        .snap_data(sd4), .busy(busy4), .out_valid(ov4), .out_ready(rdy4),
        .out_data(od4), .out_idx(oi4), .out_last(ol4), .done(dn4));

    ring_buffer_snapshot_reader #(.width(8), .depth(5)) u_dut5 (
        .clk(clk), .rst(rst), .snap_req(req5), .start_idx(st5), .snap_valid(sv5),
        .snap_data(sd5), .busy(busy5), .out_valid(ov5), .out_ready(rdy5),
        .out_data(od5), .out_idx(oi5), .out_last(ol5), .done(dn5));

    typedef struct {int dut; int cyc; int idx; int data; int last;} ent_t;
    typedef struct {int dut; int cyc;} dn_t;
    ent_t exp_q[$];
    dn_t  done_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic take(int dut, int idx, int data, int last);
        ent_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_entry", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("entry_dut", dut, e.dut);
            chk("entry_cycle", cyc, e.cyc);
            chk("entry_idx", idx, e.idx);
            chk("entry_data", data, e.data);
            chk("entry_last", last, e.last);
        end
    endtask

    task automatic take_done(int dut);
        dn_t d;
        if (done_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
        end else begin
            d = done_q.pop_front();
            chk("done_dut", dut, d.dut);
            chk("done_cycle", cyc, d.cyc);
        end
    endtask

    // Monitor: pops on every handshake and done pulse; checks hold stability on stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov4 && rdy4) begin
                take(4, int'(oi4), int'(od4), int'(ol4));
            end else if (ov4) begin
                if (exp_q.size() == 0) chk("unexpected_stall", 1, 0);
                else begin
                    chk("stall_idx", int'(oi4), exp_q[0].idx);
                    chk("stall_data", int'(od4), exp_q[0].data);
                    chk("stall_last", int'(ol4), exp_q[0].last);
                end
            end
            if (ov5 && rdy5) take(5, int'(oi5), int'(od5), int'(ol5));
            if (dn4) take_done(4);
            if (dn5) take_done(5);
        end
    end

    task automatic push(int dut, int c, int idx, int data, int last);
        exp_q.push_back('{dut, c, idx, data, last});
    endtask

    task automatic push_done(int dut, int c);
        done_q.push_back('{dut, c});
    endtask

    task automatic issue4(int start, logic [3:0] v, logic [3:0][7:0] d, output int c0);
        @(posedge clk); #1;
        req4 = 1'b1; st4 = 2'(start); sv4 = v; sd4 = d;
        c0 = cyc + 1;
        @(posedge clk); #1;
        req4 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk);
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            chk("drain_timeout", exp_q.size() + done_q.size(), 0);
            exp_q.delete();
            done_q.delete();
        end
        @(posedge clk); #1;
        chk("idle_busy4", int'(busy4), 0);
        chk("idle_busy5", int'(busy5), 0);
    endtask

    logic [3:0][7:0] base4;
    logic [3:0][7:0] ff4;
    int c0, c1;

    initial begin
        base4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ff4   = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        repeat (2) @(negedge clk);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_valid4", int'(ov4), 0);
        chk("rst_last4", int'(ol4), 0);
        chk("rst_done4", int'(dn4), 0);
        chk("rst_busy5", int'(busy5), 0);
        chk("rst_valid5", int'(ov5), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic order from slot 2
        issue4(2, 4'b1111, base4, c0);
        chk("busy_walk", int'(busy4), 1);
        push(4, c0, 2, 8'hA2, 0); push(4, c0+1, 3, 8'hA3, 0);
        push(4, c0+2, 0, 8'hA0, 0); push(4, c0+3, 1, 8'hA1, 1);
        push_done(4, c0+4);
        drain();

        // Sparse with skipped slots
        issue4(1, 4'b0101, base4, c0);
        push(4, c0+1, 2, 8'hA2, 0); push(4, c0+3, 0, 8'hA0, 1);
        push_done(4, c0+4);
        drain();

        // Backpressure on slot 3 for three cycles
        issue4(2, 4'b1111, base4, c0);
        push(4, c0, 2, 8'hA2, 0); push(4, c0+4, 3, 8'hA3, 0);
        push(4, c0+5, 0, 8'hA0, 0); push(4, c0+6, 1, 8'hA1, 1);
        push_done(4, c0+7);
        @(posedge clk); #1; rdy4 = 1'b0;
        repeat (3) @(posedge clk);
        #1; rdy4 = 1'b1;
        drain();

        // Snapshot isolation, ignored request, back-to-back capture on done
        issue4(0, 4'b1111, base4, c0);
        push(4, c0, 0, 8'hA0, 0); push(4, c0+1, 1, 8'hA1, 0);
        push(4, c0+2, 2, 8'hA2, 0); push(4, c0+3, 3, 8'hA3, 1);
        push_done(4, c0+4);
        @(posedge clk); #1; sd4 = ff4; req4 = 1'b1;
        @(posedge clk); #1; req4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("done_cycle_seen", int'(dn4), 1);
        req4 = 1'b1; st4 = 2'd0;
        c1 = cyc + 1;
        push(4, c1, 0, 8'hFF, 0); push(4, c1+1, 1, 8'hFF, 0);
        push(4, c1+2, 2, 8'hFF, 0); push(4, c1+3, 3, 8'hFF, 1);
        push_done(4, c1+4);
        @(posedge clk); #1; req4 = 1'b0;
        drain();

        // Empty snapshot
        issue4(3, 4'b0000, base4, c0);
        push_done(4, c0+4);
        drain();

        // Out-of-range start index at depth 5 falls back to slot 0
        @(posedge clk); #1;
        req5 = 1'b1; st5 = 3'd7; sv5 = 5'b01001;
        sd5 = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
        c0 = cyc + 1;
        push(5, c0, 0, 8'hB0, 0); push(5, c0+3, 3, 8'hB3, 1);
        push_done(5, c0+5);
        @(posedge clk); #1; req5 = 1'b0;
        drain();

        // Reset while slot 3 is presented
        issue4(2, 4'b1111, base4, c0);
        push(4, c0, 2, 8'hA2, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(ov4), 0);
        chk("midrst_busy", int'(busy4), 0);
        chk("midrst_done", int'(dn4), 0);
        chk("midrst_last", int'(ol4), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_queue", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", int'(busy4), 0);
        chk("post_rst_valid", int'(ov4), 0);
        issue4(1, 4'b1111, base4, c0);
        push(4, c0, 1, 8'hA1, 0); push(4, c0+1, 2, 8'hA2, 0);
        push(4, c0+2, 3, 8'hA3, 0); push(4, c0+3, 0, 8'hA0, 1);
        push_done(4, c0+4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

endmodule

// File: doc/ring_buffer_snapshot_reader.md
# ring_buffer_snapshot_reader

Read-side companion to the single-pointer ring buffer's debug view. On request it captures the buffer's parallel debug snapshot (per-slot valid and data) and streams the valid entries out one at a time over a valid/ready interface. Entries leave oldest-first, starting at a caller-supplied slot index, with the slot index and a last-entry flag attached. It sits between the ring buffer and a narrow consumer such as a display driver, UART formatter or scoreboard. It frees the ring buffer itself to keep running while the consumer drains at its own pace.

## Interface
- width, 256, data bits per slot (must match the ring buffer)
- depth, 10, number of slots (≥ 2); iw = $clog2(depth) is the index width
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- snap_req  input  1  capture request, sampled at the rising edge of clk
- start_idx  input  iw  first (oldest) slot to emit; sampled with snap_req
- snap_valid  input  [depth-1:0]  per-slot valid of the ring buffer debug view
- snap_data  input  [depth-1:0][width-1:0]  per-slot data of the ring buffer debug view
- busy  output  1  capture in progress; snap_req is ignored while busy is high
- out_valid  output  1  out_data, out_idx and out_last are meaningful
- out_ready  input  1  consumer accepts the entry when out_valid and out_ready are both high
- out_data  output  width  captured data of the current slot
- out_idx  output  iw  slot number of the current entry
- out_last  output  1  current entry is the final valid entry of this capture
- done  output  1  one-cycle pulse when a capture is finished

## Operation
- There are two states: IDLE and WALK.
- **IDLE → WALK:** taken on a clock edge with snap_req=1.
  - The shadow registers capture snap_valid and snap_data.
  - The walk pointer idx is set to start_idx. If start_idx ≥ depth, idx is set to 0.
  - The visited counter cnt is set to 0.
- **In WALK:**
  - out_valid = shadow_valid[idx].
  - out_data = shadow_data[idx], and out_idx = idx.
  - The current slot is consumed when shadow_valid[idx]=0 (skipped, one cycle per slot) or when out_valid & out_ready.
  - On consume, idx advances with wrap-around (idx = depth-1 → 0) and cnt increments.
  - When a consume occurs with cnt = depth-1, the state returns to IDLE. The next cycle carries the done pulse.
- **out_last:** high when out_valid=1 and no shadow-valid slot remains among the slots not yet visited.
  - This is a combinational look-ahead over a remaining-slot mask.
- **Outputs with no valid entry:** out_valid=0 in IDLE. out_data/out_idx hold their last value and are don't-care.
- **Backpressure:** while out_valid=1 and out_ready=0, out_data, out_idx and out_last stay stable.
- **Snapshot isolation:** changes on snap_valid/snap_data after capture do not affect the walk in progress.
- **Ignored requests:** snap_req while busy=1 is ignored and not queued.
- **Back-to-back captures:** snap_req in the cycle carrying done is accepted.
- **Empty snapshot:** if all captured slots are invalid, the block walks depth cycles with out_valid=0 throughout, then pulses done.
- **Reset (including mid-walk):**
  - State returns to IDLE.
  - busy=0, out_valid=0, out_last=0, done=0.
  - Shadow valid is cleared, and idx and cnt are zeroed.
  - No partial capture resumes after reset.

## Timing
- busy = (state == WALK). It rises in the cycle after the snap_req edge.
- The first slot is presented one cycle after the snap_req edge.
- **Throughput:** at most one entry per cycle. Each invalid slot costs exactly one cycle.
- **Capture duration:** with out_ready held high, a capture takes exactly depth cycles in WALK, regardless of the valid count.
  - done then fires in the following cycle, at snap_req edge + depth + 1.
- **Stall cost:** each cycle with out_valid=1 and out_ready=0 adds one cycle to the capture.
- **Registered outputs:** done is registered and busy is state-decoded.
- **Combinational outputs:** out_valid, out_data, out_idx and out_last are combinational from the registered state. There is no combinational path from out_ready to any output.

## Test plan
All scenarios use depth=4, width=8.
- **Basic order:** snap_valid=4'b1111, data[i]=8'hA0+i, start_idx=2, out_ready=1.
  - Required: idx/data 2/A2, 3/A3, 0/A0, 1/A1 on consecutive cycles; out_last only with 1/A1.
  - busy lasts 4 cycles; done 5 cycles after snap_req.
- **Sparse with skip:** snap_valid=4'b0101, start_idx=1, out_ready=1.
  - Required: entry 2 in cycle 2, entry 0 in cycle 4, out_last on entry 0, done at cycle 5.
- **Backpressure:** as basic order, with out_ready=0 for 3 cycles while entry 3 is presented.
  - Required: A3 and idx 3 held stable for 4 cycles; done delayed by 3 cycles; no entry lost or duplicated.
- **Snapshot isolation and ignored request:** change snap_data to 8'hFF and pulse snap_req during a walk.
  - Required: original captured values emitted; only one done.
  - Required: new capture accepted on the done cycle, emitting 8'hFF values.
- **Empty and out-of-range:** snap_valid=0, start_idx=3 gives out_valid=0 for 4 cycles, then done.
  - Then snap_valid=4'b1000 with start_idx=3'd… is not representable at depth=4, so repeat at depth=5 with start_idx=7.
  - Required: walk starts at slot 0.
- **Reset mid-walk:** assert rst during entry 1 of basic order.
  - Required: out_valid, busy and done go 0 immediately; after release the block is idle and a new snap_req restarts from start_idx.
